// File: rtl/plane_velocity_solver.sv
// -----------------------------------------------------------------------------
// plane_velocity_solver
//   Responder side of the plane_state velocity handshake. On a request it
//   captures speed, pitch and heading, resolves them into world-frame velocity
//   (v_x east, v_y up, v_z north) using a 91-entry quarter-wave sine ROM and a
//   single shared multiplier, then pulses velocities_ready for one cycle.
//
// Ports
//   clk                 in   system clock
//   reset               in   synchronous, active-high; aborts any transaction
//   request_velocities  in   level request, held until velocities_ready is seen
//   speed               in   unsigned airspeed (COORD_WIDTH)
//   pitch               in   signed degrees, +nose up (ANGLE_WIDTH)
//   heading             in   unsigned degrees, 0 = north (+z), 90 = east (+x)
//   velocities_ready    out  one-cycle pulse; v_* valid from this cycle on
//   v_x, v_y, v_z       out  signed velocity, held between transactions
//   busy                out  high from capture until the ready pulse ends
//   angle_clamped       out  sticky flag: an input angle was clamped/folded
//
// Configuration
//   PLANE_VEL_ROUND_EN  when defined, 2^(TRIG_FRAC-1) is added before every
//                       shift (round half up); otherwise results are floored.
//                       Latency and FSM are identical in both builds.
// -----------------------------------------------------------------------------
module plane_velocity_solver #(
  parameter int COORD_WIDTH = 32,
  parameter int ANGLE_WIDTH = 16,
  parameter int TRIG_FRAC   = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          request_velocities,
  input  logic [COORD_WIDTH-1:0]        speed,
  input  logic signed [ANGLE_WIDTH-1:0] pitch,
  input  logic [ANGLE_WIDTH-1:0]        heading,
  output logic                          velocities_ready,
  output logic signed [COORD_WIDTH-1:0] v_x,
  output logic signed [COORD_WIDTH-1:0] v_y,
  output logic signed [COORD_WIDTH-1:0] v_z,
  output logic                          busy,
  output logic                          angle_clamped
);

  localparam int PW = COORD_WIDTH + ANGLE_WIDTH;

  // Largest positive signed speed; larger unsigned inputs saturate here.
  localparam logic [COORD_WIDTH-1:0] SPD_MAX = {1'b0, {(COORD_WIDTH-1){1'b1}}};
  localparam logic signed [ANGLE_WIDTH-1:0] P_MAX = ANGLE_WIDTH'(90);
  localparam logic signed [ANGLE_WIDTH-1:0] P_MIN = ANGLE_WIDTH'(-90);
  localparam logic [ANGLE_WIDTH-1:0] H_FULL  = ANGLE_WIDTH'(360);
  localparam logic [ANGLE_WIDTH-1:0] H_TWICE = ANGLE_WIDTH'(720);
`ifdef PLANE_VEL_ROUND_EN
  localparam logic signed [PW-1:0] RND_BIAS = PW'(1) << (TRIG_FRAC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_VY, S_HOR, S_VX, S_VZ, S_DONE, S_HOLD
  } state_t;

  // Quarter-wave table: round(16384 * sin(k deg)), k = 0..90.
  function automatic logic [14:0] sin_rom(input logic [8:0] k);
    logic [14:0] v;
    case (k)
      9'd0:  v = 15'd0;     9'd1:  v = 15'd286;   9'd2:  v = 15'd572;   9'd3:  v = 15'd857;
      9'd4:  v = 15'd1143;  9'd5:  v = 15'd1428;  9'd6:  v = 15'd1713;  9'd7:  v = 15'd1997;
      9'd8:  v = 15'd2280;  9'd9:  v = 15'd2563;  9'd10: v = 15'd2845;  9'd11: v = 15'd3126;
      9'd12: v = 15'd3406;  9'd13: v = 15'd3686;  9'd14: v = 15'd3964;  9'd15: v = 15'd4240;
      9'd16: v = 15'd4516;  9'd17: v = 15'd4790;  9'd18: v = 15'd5063;  9'd19: v = 15'd5334;
      9'd20: v = 15'd5604;  9'd21: v = 15'd5872;  9'd22: v = 15'd6138;  9'd23: v = 15'd6402;
      9'd24: v = 15'd6664;  9'd25: v = 15'd6924;  9'd26: v = 15'd7182;  9'd27: v = 15'd7438;
      9'd28: v = 15'd7692;  9'd29: v = 15'd7943;  9'd30: v = 15'd8192;  9'd31: v = 15'd8438;
      9'd32: v = 15'd8682;  9'd33: v = 15'd8923;  9'd34: v = 15'd9162;  9'd35: v = 15'd9397;
      9'd36: v = 15'd9630;  9'd37: v = 15'd9860;  9'd38: v = 15'd10087; 9'd39: v = 15'd10311;
      9'd40: v = 15'd10531; 9'd41: v = 15'd10749; 9'd42: v = 15'd10963; 9'd43: v = 15'd11174;
      9'd44: v = 15'd11381; 9'd45: v = 15'd11585; 9'd46: v = 15'd11786; 9'd47: v = 15'd11982;
      9'd48: v = 15'd12176; 9'd49: v = 15'd12365; 9'd50: v = 15'd12551; 9'd51: v = 15'd12733;
      9'd52: v = 15'd12911; 9'd53: v = 15'd13085; 9'd54: v = 15'd13255; 9'd55: v = 15'd13421;
      9'd56: v = 15'd13583; 9'd57: v = 15'd13741; 9'd58: v = 15'd13894; 9'd59: v = 15'd14044;
      9'd60: v = 15'd14189; 9'd61: v = 15'd14330; 9'd62: v = 15'd14466; 9'd63: v = 15'd14598;
      9'd64: v = 15'd14726; 9'd65: v = 15'd14849; 9'd66: v = 15'd14968; 9'd67: v = 15'd15082;
      9'd68: v = 15'd15191; 9'd69: v = 15'd15296; 9'd70: v = 15'd15396; 9'd71: v = 15'd15491;
      9'd72: v = 15'd15582; 9'd73: v = 15'd15668; 9'd74: v = 15'd15749; 9'd75: v = 15'd15826;
      9'd76: v = 15'd15897; 9'd77: v = 15'd15964; 9'd78: v = 15'd16026; 9'd79: v = 15'd16083;
      9'd80: v = 15'd16135; 9'd81: v = 15'd16182; 9'd82: v = 15'd16225; 9'd83: v = 15'd16262;
      9'd84: v = 15'd16294; 9'd85: v = 15'd16321; 9'd86: v = 15'd16344; 9'd87: v = 15'd16362;
      9'd88: v = 15'd16374; 9'd89: v = 15'd16382; 9'd90: v = 15'd16384;
      default: v = 15'd0;
    endcase
    return v;
  endfunction

  // Full-circle sine for 0..359 degrees, folded onto the quarter-wave table.
  function automatic logic signed [ANGLE_WIDTH-1:0] sin_deg(input logic [8:0] d);
    logic [8:0] idx;
    logic       neg;
    logic signed [ANGLE_WIDTH-1:0] mag;
    if (d <= 9'd90) begin
      idx = d;            neg = 1'b0;
    end else if (d <= 9'd180) begin
      idx = 9'd180 - d;   neg = 1'b0;
    end else if (d <= 9'd270) begin
      idx = d - 9'd180;   neg = 1'b1;
    end else begin
      idx = 9'd360 - d;   neg = 1'b1;
    end
    mag = ANGLE_WIDTH'(sin_rom(idx));
    return neg ? -mag : mag;
  endfunction

  state_t                         state_q;
  logic signed [COORD_WIDTH-1:0]  spd_q;
  logic signed [ANGLE_WIDTH-1:0]  pitch_q;
  logic [ANGLE_WIDTH-1:0]         heading_q;
  logic signed [ANGLE_WIDTH-1:0]  sin_p_q, cos_p_q, sin_h_q, cos_h_q;
  logic signed [COORD_WIDTH-1:0]  vy_r_q, hor_q, vx_r_q;
  logic signed [COORD_WIDTH-1:0]  v_x_q, v_y_q, v_z_q;
  logic                           ready_q, busy_q, clamped_q;

  logic signed [ANGLE_WIDTH-1:0]  p_cl_s, p_mag_s, sin_p_s, cos_p_s, sin_h_s, cos_h_s;
  logic                           p_clamp_s, p_neg_s, h_clamp_s;
  logic [8:0]                     p_abs_s, h_fold_s, h_cos_arg_s;
  logic signed [COORD_WIDTH-1:0]  mul_a_s, mul_res_s;
  logic signed [ANGLE_WIDTH-1:0]  mul_b_s;
  logic signed [PW-1:0]           a_ext_s, b_ext_s, prod_s, sum_s;

  // Angle normalisation and trig lookup from the captured angles.
  always_comb begin
    p_cl_s    = pitch_q;
    p_clamp_s = 1'b0;
    if (pitch_q > P_MAX) begin
      p_cl_s    = P_MAX;
      p_clamp_s = 1'b1;
    end else if (pitch_q < P_MIN) begin
      p_cl_s    = P_MIN;
      p_clamp_s = 1'b1;
    end else begin
      p_cl_s    = pitch_q;
      p_clamp_s = 1'b0;
    end
    p_neg_s = p_cl_s[ANGLE_WIDTH-1];
    p_abs_s = p_neg_s ? 9'(-p_cl_s) : 9'(p_cl_s);
    p_mag_s = ANGLE_WIDTH'(sin_rom(p_abs_s));
    sin_p_s = p_neg_s ? -p_mag_s : p_mag_s;
    cos_p_s = ANGLE_WIDTH'(sin_rom(9'd90 - p_abs_s));

    h_fold_s  = 9'd0;
    h_clamp_s = 1'b0;
    if (heading_q < H_FULL) begin
      h_fold_s  = 9'(heading_q);
      h_clamp_s = 1'b0;
    end else if (heading_q < H_TWICE) begin
      h_fold_s  = 9'(heading_q - H_FULL);
      h_clamp_s = 1'b1;
    end else begin
      h_fold_s  = 9'd0;
      h_clamp_s = 1'b1;
    end
    // cos(h) = sin((h + 90) mod 360)
    h_cos_arg_s = (h_fold_s >= 9'd270) ? (h_fold_s - 9'd270) : (h_fold_s + 9'd90);
    sin_h_s     = sin_deg(h_fold_s);
    cos_h_s     = sin_deg(h_cos_arg_s);
  end

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_a_s = {COORD_WIDTH{1'b0}};
    mul_b_s = {ANGLE_WIDTH{1'b0}};
    case (state_q)
      S_VY:    begin mul_a_s = spd_q; mul_b_s = sin_p_q; end
      S_HOR:   begin mul_a_s = spd_q; mul_b_s = cos_p_q; end
      S_VX:    begin mul_a_s = hor_q; mul_b_s = sin_h_q; end
      S_VZ:    begin mul_a_s = hor_q; mul_b_s = cos_h_q; end
      default: begin mul_a_s = {COORD_WIDTH{1'b0}}; mul_b_s = {ANGLE_WIDTH{1'b0}}; end
    endcase
  end

  // Signed product, optional rounding bias, arithmetic shift back to integer.
  always_comb begin
    a_ext_s = {{ANGLE_WIDTH{mul_a_s[COORD_WIDTH-1]}}, mul_a_s};
    b_ext_s = {{COORD_WIDTH{mul_b_s[ANGLE_WIDTH-1]}}, mul_b_s};
    prod_s  = a_ext_s * b_ext_s;
`ifdef PLANE_VEL_ROUND_EN
    sum_s   = prod_s + RND_BIAS;
`else
    sum_s   = prod_s;
`endif
    // Speed is saturated to the signed range, so the result cannot overflow.
    mul_res_s = COORD_WIDTH'(sum_s >>> TRIG_FRAC);
  end

  // Handshake FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      spd_q     <= {COORD_WIDTH{1'b0}};
      pitch_q   <= {ANGLE_WIDTH{1'b0}};
      heading_q <= {ANGLE_WIDTH{1'b0}};
      sin_p_q   <= {ANGLE_WIDTH{1'b0}};
      cos_p_q   <= {ANGLE_WIDTH{1'b0}};
      sin_h_q   <= {ANGLE_WIDTH{1'b0}};
      cos_h_q   <= {ANGLE_WIDTH{1'b0}};
      vy_r_q    <= {COORD_WIDTH{1'b0}};
      hor_q     <= {COORD_WIDTH{1'b0}};
      vx_r_q    <= {COORD_WIDTH{1'b0}};
      v_x_q     <= {COORD_WIDTH{1'b0}};
      v_y_q     <= {COORD_WIDTH{1'b0}};
      v_z_q     <= {COORD_WIDTH{1'b0}};
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (request_velocities) begin
            spd_q     <= (speed > SPD_MAX) ? SPD_MAX : speed;
            pitch_q   <= pitch;
            heading_q <= heading;
            busy_q    <= 1'b1;
            state_q   <= S_NORM;
          end else begin
            state_q   <= S_IDLE;
          end
        end
        S_NORM: begin
          sin_p_q   <= sin_p_s;
          cos_p_q   <= cos_p_s;
          sin_h_q   <= sin_h_s;
          cos_h_q   <= cos_h_s;
          clamped_q <= clamped_q | p_clamp_s | h_clamp_s;
          state_q   <= S_VY;
        end
        S_VY: begin
          vy_r_q  <= mul_res_s;
          state_q <= S_HOR;
        end
        S_HOR: begin
          hor_q   <= mul_res_s;
          state_q <= S_VX;
        end
        S_VX: begin
          vx_r_q  <= mul_res_s;
          state_q <= S_VZ;
        end
        S_VZ: begin
          // Publish all three components together with the ready pulse.
          v_x_q   <= vx_r_q;
          v_y_q   <= vy_r_q;
          v_z_q   <= mul_res_s;
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= request_velocities ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          // A still-held request must drop before another capture is allowed.
          state_q <= request_velocities ? S_HOLD : S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign velocities_ready = ready_q;
  assign v_x              = v_x_q;
  assign v_y              = v_y_q;
  assign v_z              = v_z_q;
  assign busy             = busy_q;
  assign angle_clamped    = clamped_q;

endmodule

// File: tb/tb_plane_velocity_solver.sv
// -----------------------------------------------------------------------------
// tb_plane_velocity_solver
//   Directed, table-driven bench for plane_velocity_solver. Each table row holds
//   the inputs of one transaction and hand-computed velocities; a few
//   hand-written sequences cover held requests and reset in mid-transaction.
// -----------------------------------------------------------------------------
module tb_plane_velocity_solver;

  logic                clk;
  logic                reset;
  logic                request_velocities;
  logic [31:0]         speed;
  logic signed [15:0]  pitch;
  logic [15:0]         heading;
  logic                velocities_ready;
  logic signed [31:0]  v_x, v_y, v_z;
  logic                busy;
  logic                angle_clamped;

  int errors = 0;
  int checks = 0;

  plane_velocity_solver dut (
    .clk                (clk),
    .reset              (reset),
    .request_velocities (request_velocities),
    .speed              (speed),
    .pitch              (pitch),
    .heading            (heading),
    .velocities_ready   (velocities_ready),
    .v_x                (v_x),
    .v_y                (v_y),
    .v_z                (v_z),
    .busy               (busy),
    .angle_clamped      (angle_clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        spd;
    logic signed [15:0] pit;
    logic [15:0]        hdg;
    logic signed [31:0] ex;
    logic signed [31:0] ey;
    logic signed [31:0] ez;
    logic               eclamp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] s, input int p, input int h,
                         input int x, input int y, input int z, input logic c);
    vec_t v;
    v.spd = s;
    v.pit = 16'(p);
    v.hdg = 16'(h);
    v.ex = x;
    v.ey = y;
    v.ez = z;
    v.eclamp = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits for the ready pulse after a capture edge; returns the edge index
  // (relative to the capture edge t) at which the initiator sees ready, or -1.
  // After the capture edge the inputs are scrambled to prove they are not resampled.
  task automatic wait_ready(output int edge_no);
    edge_no = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        speed   = 32'hDEAD_BEEF;
        pitch   = 16'sd77;
        heading = 16'd900;
      end
      if (velocities_ready) begin
        edge_no = k + 1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;

    // speed, pitch, heading -> v_x, v_y, v_z, angle_clamped
    add_vec(32'd100,  0,   0,    0,   0,  100, 1'b0);
    add_vec(32'd100,  0,  90,  100,   0,    0, 1'b0);
    add_vec(32'd100,  0, 180,    0,   0, -100, 1'b0);
    add_vec(32'd100,  0, 270, -100,   0,    0, 1'b0);
`ifdef PLANE_VEL_ROUND_EN
    add_vec(32'd100, 30,   0,    0,  50,   87, 1'b0);
`else
    add_vec(32'd100, 30,   0,    0,  50,   86, 1'b0);
`endif
    add_vec(32'd1000, 0,  45,  707,   0,  707, 1'b0);
`ifdef PLANE_VEL_ROUND_EN
    add_vec(32'd100, -30, 225, -62, -50,  -62, 1'b0);
    add_vec(32'd7,   60, 120,    3,   6,   -2, 1'b0);
`else
    add_vec(32'd100, -30, 225, -61, -50,  -61, 1'b0);
    add_vec(32'd7,   60, 120,    2,   6,   -2, 1'b0);
`endif
    add_vec(32'hFFFF_FFFF, 0, 0, 0,   0, 2147483647, 1'b0);
    add_vec(32'd10,   0, 450,   10,   0,    0, 1'b1);
    add_vec(32'd10, -120,  0,    0, -10,    0, 1'b1);
    add_vec(32'd10,   0, 800,    0,   0,   10, 1'b1);
    add_vec(32'd10, 200,   0,    0,  10,    0, 1'b1);

    reset = 1'b1;
    request_velocities = 1'b0;
    speed = 32'd0;
    pitch = 16'sd0;
    heading = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", velocities_ready, 0);
    chk("rst_vx", v_x, 0);
    chk("rst_vy", v_y, 0);
    chk("rst_vz", v_z, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clamped", angle_clamped, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      speed   = vecs[i].spd;
      pitch   = vecs[i].pit;
      heading = vecs[i].hdg;
      request_velocities = 1'b1;
      wait_ready(lat);
      chk($sformatf("vec%0d_ready_edge", i), lat, 6);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      chk($sformatf("vec%0d_vx", i), v_x, vecs[i].ex);
      chk($sformatf("vec%0d_vy", i), v_y, vecs[i].ey);
      chk($sformatf("vec%0d_vz", i), v_z, vecs[i].ez);
      chk($sformatf("vec%0d_clamped", i), angle_clamped, vecs[i].eclamp);
      request_velocities = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pulse_width", i), velocities_ready, 0);
      chk($sformatf("vec%0d_busy_end", i), busy, 0);
      chk($sformatf("vec%0d_vz_held", i), v_z, vecs[i].ez);
    end

    // Held request: exactly one pulse, then a 1-cycle drop re-arms the handshake.
    speed = 32'd100;
    pitch = 16'sd0;
    heading = 16'd0;
    request_velocities = 1'b1;
    wait_ready(lat);
    chk("hold_first_edge", lat, 6);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (velocities_ready) pulses++;
    end
    chk("hold_extra_pulses", pulses, 0);
    request_velocities = 1'b0;
    @(posedge clk);
    #1;
    speed = 32'd100;
    pitch = 16'sd0;
    heading = 16'd90;
    request_velocities = 1'b1;
    wait_ready(lat);
    chk("hold_second_edge", lat, 6);
    chk("hold_second_vx", v_x, 100);
    chk("hold_second_vz", v_z, 0);

    // Reset while in VX aborts and clears; a still-high request restarts.
    request_velocities = 1'b0;
    @(posedge clk);
    #1;
    speed = 32'd100;
    pitch = 16'sd0;
    heading = 16'd0;
    request_velocities = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", velocities_ready, 0);
    chk("abort_vx", v_x, 0);
    chk("abort_vy", v_y, 0);
    chk("abort_vz", v_z, 0);
    chk("abort_busy", busy, 0);
    chk("abort_clamped", angle_clamped, 0);
    speed = 32'd100;
    pitch = 16'sd30;
    heading = 16'd0;
    reset = 1'b0;
    wait_ready(lat);
    chk("restart_edge", lat, 6);
    chk("restart_vy", v_y, 50);
`ifdef PLANE_VEL_ROUND_EN
    chk("restart_vz", v_z, 87);
`else
    chk("restart_vz", v_z, 86);
`endif
    request_velocities = 1'b0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
